nasti_narrower_reader: RTL and testbench

NASTI_NARROWER_READER -- requirements
Module: nasti_narrower_reader

---
 rtl/nasti_narrower_pkg.sv | 58 +++++
 rtl/nasti_narrower_reader.sv | 226 ++++++++++++++++++++++
 tb/tb_nasti_narrower_reader.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/nasti_narrower_pkg.sv
// -----------------------------------------------------------------------------
// nasti_narrower_pkg
// Shared helpers for the NASTI read-path narrower. They turn a wide-side burst
// description into the narrow-side burst and locate narrow beats inside a
// wide beat. All helpers work on plain ints so that any module can call them
// with its own width parameters.
//   ratio        : number of slave lanes in one master beat
//   ratio_offset : slave lane addressed by an address within a master beat
//   slave_step   : byte advance per slave beat for a given master beat size
//   burst_index  : slave-beat index of an address within one master beat
//   slave_len    : AxLEN of the narrowed burst
//   slave_size   : AxSIZE of the narrowed burst
// -----------------------------------------------------------------------------
package nasti_narrower_pkg;

  localparam logic [1:0] BURST_INCR = 2'b01;

  function automatic int ratio(input int master_width, input int slave_width);
    return master_width / slave_width;
  endfunction

  // addr_lo holds the low address byte; 8 bits cover every legal AxSIZE.
  function automatic int ratio_offset(input logic [7:0] addr_lo, input int scs,
                                      input int rat);
    return (int'(addr_lo) >> scs) & (rat - 1);
  endfunction

  function automatic int slave_step(input logic [2:0] size, input int scs);
    return (int'(size) > scs) ? (1 << scs) : (1 << size);
  endfunction

  function automatic int burst_index(input logic [7:0] addr_lo,
                                     input logic [2:0] size, input int scs);
    return (int'(addr_lo) & ((1 << size) - 1)) >> scs;
  endfunction

  // A wide beat splits into 2^(size-scs) narrow beats; an unaligned start
  // skips the narrow beats below the start address in the first wide beat.
  function automatic logic [7:0] slave_len(input logic [7:0] len,
                                           input logic [2:0] size,
                                           input logic [7:0] addr_lo,
                                           input int scs);
    int shift;
    int res;
    if (int'(size) > scs) begin
      shift = int'(size) - scs;
      res   = (int'(len) << shift) + (1 << shift)
              - burst_index(addr_lo, size, scs) - 1;
      return 8'(res);
    end
    return len;
  endfunction

  function automatic logic [2:0] slave_size(input logic [2:0] size, input int scs);
    return (int'(size) > scs) ? 3'(scs) : size;
  endfunction

endpackage

// File: rtl/nasti_narrower_reader.sv
// -----------------------------------------------------------------------------
// nasti_narrower_reader
// Converts one wide NASTI read burst into a narrow-slave burst and packs the
// narrow read beats back into wide master beats. One burst in flight at a time.
//
// Ports
//   clk, rstn              clock, asynchronous active-low reset
//   master_ar_*            wide read request (registered on handshake)
//   master_r_*             wide read data, packed from slave beats
//   slave_ar_*             narrowed read request
//   slave_r_*              narrow read data
//
// Optional build macro
//   NASTI_NARROWER_READER_ASSERT_EN : stop simulation on an accepted request
//   that is not INCR or that exceeds the supported burst length.
// -----------------------------------------------------------------------------
module nasti_narrower_reader
  import nasti_narrower_pkg::*;
#(
  parameter int ID_WIDTH          = 2,
  parameter int ADDR_WIDTH        = 32,
  parameter int MASTER_DATA_WIDTH = 64,
  parameter int SLAVE_DATA_WIDTH  = 32,
  parameter int USER_WIDTH        = 1
) (
  input  logic                         clk,
  input  logic                         rstn,

  input  logic [ID_WIDTH-1:0]          master_ar_id,
  input  logic [ADDR_WIDTH-1:0]        master_ar_addr,
  input  logic [7:0]                   master_ar_len,
  input  logic [2:0]                   master_ar_size,
  input  logic [1:0]                   master_ar_burst,
  input  logic                         master_ar_lock,
  input  logic [3:0]                   master_ar_cache,
  input  logic [2:0]                   master_ar_prot,
  input  logic [3:0]                   master_ar_qos,
  input  logic [3:0]                   master_ar_region,
  input  logic [USER_WIDTH-1:0]        master_ar_user,
  input  logic                         master_ar_valid,
  output logic                         master_ar_ready,

  output logic [ID_WIDTH-1:0]          master_r_id,
  output logic [MASTER_DATA_WIDTH-1:0] master_r_data,
  output logic [1:0]                   master_r_resp,
  output logic                         master_r_last,
  output logic [USER_WIDTH-1:0]        master_r_user,
  output logic                         master_r_valid,
  input  logic                         master_r_ready,

  output logic [ID_WIDTH-1:0]          slave_ar_id,
  output logic [ADDR_WIDTH-1:0]        slave_ar_addr,
  output logic [7:0]                   slave_ar_len,
  output logic [2:0]                   slave_ar_size,
  output logic [1:0]                   slave_ar_burst,
  output logic                         slave_ar_lock,
  output logic [3:0]                   slave_ar_cache,
  output logic [2:0]                   slave_ar_prot,
  output logic [3:0]                   slave_ar_qos,
  output logic [3:0]                   slave_ar_region,
  output logic [USER_WIDTH-1:0]        slave_ar_user,
  output logic                         slave_ar_valid,
  input  logic                         slave_ar_ready,

  input  logic [ID_WIDTH-1:0]          slave_r_id,
  input  logic [SLAVE_DATA_WIDTH-1:0]  slave_r_data,
  input  logic [1:0]                   slave_r_resp,
  input  logic                         slave_r_last,
  input  logic [USER_WIDTH-1:0]        slave_r_user,
  input  logic                         slave_r_valid,
  output logic                         slave_r_ready
);

  localparam int SCS   = $clog2(SLAVE_DATA_WIDTH / 8);
  localparam int MCS   = $clog2(MASTER_DATA_WIDTH / 8);
  localparam int RATIO = ratio(MASTER_DATA_WIDTH, SLAVE_DATA_WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_AR, S_R} state_t;

  typedef struct packed {
    logic [ID_WIDTH-1:0]   id;
    logic [ADDR_WIDTH-1:0] addr;
    logic [7:0]            len;
    logic [2:0]            size;
    logic [1:0]            burst;
    logic                  lock;
    logic [3:0]            cache;
    logic [2:0]            prot;
    logic [3:0]            qos;
    logic [3:0]            region;
    logic [USER_WIDTH-1:0] user;
  } nasti_req_t;

  state_t                state, state_next;
  nasti_req_t            req;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ADDR_WIDTH-1:0] r_addr_next;

  logic ar_fire, slave_r_fire, master_r_fire;
  logic group_close;
  int   step_bytes, size_bytes, addr_mod, beat_lane;

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= S_IDLE;
    end else begin
      // NOTE: registers take non-blocking assignments so every flop samples
      // the pre-edge values, independent of statement order.
      state <= state_next;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first; a path that left
    // one unassigned would infer a latch.
    state_next      = state;
    master_ar_ready = 1'b0;
    slave_ar_valid  = 1'b0;
    slave_r_ready   = 1'b0;
    unique case (state)
      S_IDLE: begin
        master_ar_ready = 1'b1;
        if (master_ar_valid) state_next = S_AR;
      end
      S_AR: begin
        slave_ar_valid = 1'b1;
        if (slave_ar_ready) state_next = S_R;
      end
      S_R: begin
        // Stall the slave while a packed beat waits, so the buffer is stable.
        slave_r_ready = !master_r_valid;
        if (master_r_valid && master_r_ready && master_r_last) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign ar_fire       = master_ar_valid && master_ar_ready;
  assign slave_r_fire  = slave_r_valid && slave_r_ready;
  assign master_r_fire = master_r_valid && master_r_ready;

  // ---------------------------------------------------------------------------
  // Narrowed request
  // ---------------------------------------------------------------------------
  assign slave_ar_id     = req.id;
  assign slave_ar_addr   = req.addr;
  assign slave_ar_len    = slave_len(req.len, req.size, req.addr[7:0], SCS);
  assign slave_ar_size   = slave_size(req.size, SCS);
  assign slave_ar_burst  = req.burst;
  assign slave_ar_lock   = req.lock;
  assign slave_ar_cache  = req.cache;
  assign slave_ar_prot   = req.prot;
  assign slave_ar_qos    = req.qos;
  assign slave_ar_region = req.region;
  assign slave_ar_user   = req.user;

  // ---------------------------------------------------------------------------
  // Beat packing: r_addr walks the narrow beats; a group closes when the next
  // narrow beat would cross into the following master beat.
  // ---------------------------------------------------------------------------
  always_comb begin
    step_bytes  = slave_step(req.size, SCS);
    size_bytes  = 1 << req.size;
    addr_mod    = int'(r_addr[7:0]) & (size_bytes - 1);
    beat_lane   = ratio_offset(r_addr[7:0], SCS, RATIO);
    group_close = ((addr_mod + step_bytes) >= size_bytes) || slave_r_last;
    r_addr_next = (r_addr & ~ADDR_WIDTH'(step_bytes - 1)) + ADDR_WIDTH'(step_bytes);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      // NOTE: the data buffer is reset, not just its valid flag, because
      // lanes skipped in a group must read as zero after reset too.
      req            <= '0;
      r_addr         <= '0;
      master_r_data  <= '0;
      master_r_resp  <= '0;
      master_r_last  <= 1'b0;
      master_r_id    <= '0;
      master_r_user  <= '0;
      master_r_valid <= 1'b0;
    end else begin
      if (ar_fire) begin
        req <= '{id: master_ar_id, addr: master_ar_addr, len: master_ar_len,
                 size: master_ar_size, burst: master_ar_burst,
                 lock: master_ar_lock, cache: master_ar_cache,
                 prot: master_ar_prot, qos: master_ar_qos,
                 region: master_ar_region, user: master_ar_user};
        r_addr <= master_ar_addr;
      end

      // The two fires are mutually exclusive: slave_r_ready is low while
      // master_r_valid is high.
      if (master_r_fire) begin
        master_r_valid <= 1'b0;
        master_r_data  <= '0;
        master_r_resp  <= '0;
      end else if (slave_r_fire) begin
        master_r_data[beat_lane*SLAVE_DATA_WIDTH +: SLAVE_DATA_WIDTH] <= slave_r_data;
        if (slave_r_resp > master_r_resp) master_r_resp <= slave_r_resp;
        master_r_id   <= slave_r_id;
        master_r_user <= slave_r_user;
        r_addr        <= r_addr_next;
        if (group_close) begin
          master_r_valid <= 1'b1;
          master_r_last  <= slave_r_last;
        end
      end
    end
  end

`ifdef NASTI_NARROWER_READER_ASSERT_EN
  always_ff @(posedge clk) begin
    if (rstn && ar_fire) begin
      if (master_ar_burst != BURST_INCR ||
          ((1 << master_ar_size) * (int'(master_ar_len) + 1)) > 32 * SLAVE_DATA_WIDTH)
        $fatal(1, "nasti_narrower_reader: unsupported read burst");
    end
  end
`else
`endif

endmodule

// File: tb/tb_nasti_narrower_reader.sv
// -----------------------------------------------------------------------------
// tb_nasti_narrower_reader
// Directed bench for the 64-bit master / 32-bit slave read narrower. Stimulus
// tasks push the expected slave requests and packed master beats into queues;
// independent monitors pop and compare whenever the DUT hands something over.
// -----------------------------------------------------------------------------
module tb_nasti_narrower_reader;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;

  logic [1:0]  master_ar_id = '0;
  logic [31:0] master_ar_addr = '0;
  logic [7:0]  master_ar_len = '0;
  logic [2:0]  master_ar_size = '0;
  logic [1:0]  master_ar_burst = 2'b01;
  logic        master_ar_lock = 1'b0;
  logic [3:0]  master_ar_cache = 4'h3;
  logic [2:0]  master_ar_prot = 3'h0;
  logic [3:0]  master_ar_qos = 4'h0;
  logic [3:0]  master_ar_region = 4'h0;
  logic [0:0]  master_ar_user = 1'b0;
  logic        master_ar_valid = 1'b0;
  logic        master_ar_ready;

  logic [1:0]  master_r_id;
  logic [63:0] master_r_data;
  logic [1:0]  master_r_resp;
  logic        master_r_last;
  logic [0:0]  master_r_user;
  logic        master_r_valid;
  logic        master_r_ready = 1'b1;

  logic [1:0]  slave_ar_id;
  logic [31:0] slave_ar_addr;
  logic [7:0]  slave_ar_len;
  logic [2:0]  slave_ar_size;
  logic [1:0]  slave_ar_burst;
  logic        slave_ar_lock;
  logic [3:0]  slave_ar_cache;
  logic [2:0]  slave_ar_prot;
  logic [3:0]  slave_ar_qos;
  logic [3:0]  slave_ar_region;
  logic [0:0]  slave_ar_user;
  logic        slave_ar_valid;
  logic        slave_ar_ready = 1'b1;

  logic [1:0]  slave_r_id = '0;
  logic [31:0] slave_r_data = '0;
  logic [1:0]  slave_r_resp = '0;
  logic        slave_r_last = 1'b0;
  logic [0:0]  slave_r_user = 1'b1;
  logic        slave_r_valid = 1'b0;
  logic        slave_r_ready;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  id;
  } ar_exp_t;

  typedef struct {
    logic [63:0] data;
    logic [1:0]  resp;
    logic        last;
    logic [1:0]  id;
  } r_exp_t;

  ar_exp_t exp_ar[$];
  r_exp_t  exp_r[$];

  always #5 clk = ~clk;

  nasti_narrower_reader dut (
    .clk(clk), .rstn(rstn),
    .master_ar_id(master_ar_id), .master_ar_addr(master_ar_addr),
    .master_ar_len(master_ar_len), .master_ar_size(master_ar_size),
    .master_ar_burst(master_ar_burst), .master_ar_lock(master_ar_lock),
    .master_ar_cache(master_ar_cache), .master_ar_prot(master_ar_prot),
    .master_ar_qos(master_ar_qos), .master_ar_region(master_ar_region),
    .master_ar_user(master_ar_user), .master_ar_valid(master_ar_valid),
    .master_ar_ready(master_ar_ready),
    .master_r_id(master_r_id), .master_r_data(master_r_data),
    .master_r_resp(master_r_resp), .master_r_last(master_r_last),
    .master_r_user(master_r_user), .master_r_valid(master_r_valid),
    .master_r_ready(master_r_ready),
    .slave_ar_id(slave_ar_id), .slave_ar_addr(slave_ar_addr),
    .slave_ar_len(slave_ar_len), .slave_ar_size(slave_ar_size),
    .slave_ar_burst(slave_ar_burst), .slave_ar_lock(slave_ar_lock),
    .slave_ar_cache(slave_ar_cache), .slave_ar_prot(slave_ar_prot),
    .slave_ar_qos(slave_ar_qos), .slave_ar_region(slave_ar_region),
    .slave_ar_user(slave_ar_user), .slave_ar_valid(slave_ar_valid),
    .slave_ar_ready(slave_ar_ready),
    .slave_r_id(slave_r_id), .slave_r_data(slave_r_data),
    .slave_r_resp(slave_r_resp), .slave_r_last(slave_r_last),
    .slave_r_user(slave_r_user), .slave_r_valid(slave_r_valid),
    .slave_r_ready(slave_r_ready)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Slave AR monitor
  always @(negedge clk) begin
    if (rstn && slave_ar_valid && slave_ar_ready) begin
      ar_exp_t e;
      if (exp_ar.size() == 0) begin
        check("slave_ar_unexpected", 1, 0);
      end else begin
        e = exp_ar.pop_front();
        check("slave_ar_addr", slave_ar_addr, e.addr);
        check("slave_ar_len", slave_ar_len, e.len);
        check("slave_ar_size", slave_ar_size, e.size);
        check("slave_ar_id", slave_ar_id, e.id);
        check("slave_ar_burst", slave_ar_burst, 2'b01);
        check("slave_ar_cache", slave_ar_cache, 4'h3);
      end
    end
  end

  // Master R monitor
  always @(negedge clk) begin
    if (rstn && master_r_valid && master_r_ready) begin
      r_exp_t e;
      if (exp_r.size() == 0) begin
        check("master_r_unexpected", 1, 0);
      end else begin
        e = exp_r.pop_front();
        check("master_r_data", master_r_data, e.data);
        check("master_r_resp", master_r_resp, e.resp);
        check("master_r_last", master_r_last, e.last);
        check("master_r_id", master_r_id, e.id);
        check("master_r_user", master_r_user, 1'b1);
      end
    end
  end

  task automatic push_r(input logic [63:0] data, input logic [1:0] resp,
                        input logic last, input logic [1:0] id);
    exp_r.push_back('{data: data, resp: resp, last: last, id: id});
  endtask

  task automatic send_ar(input logic [1:0] id, input logic [31:0] addr,
                         input logic [7:0] len, input logic [2:0] size,
                         input logic [7:0] exp_len, input logic [2:0] exp_size);
    logic ok;
    ok = 1'b0;
    exp_ar.push_back('{addr: addr, len: exp_len, size: exp_size, id: id});
    @(posedge clk); #1;
    master_ar_valid = 1'b1;
    master_ar_id    = id;
    master_ar_addr  = addr;
    master_ar_len   = len;
    master_ar_size  = size;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (master_ar_ready) begin ok = 1'b1; break; end
    end
    check("master_ar_accept", ok, 1'b1);
    @(posedge clk); #1;
    master_ar_valid = 1'b0;
  endtask

  task automatic send_beat(input logic [1:0] id, input logic [31:0] data,
                           input logic [1:0] resp, input logic last);
    logic ok;
    ok = 1'b0;
    @(posedge clk); #1;
    slave_r_valid = 1'b1;
    slave_r_id    = id;
    slave_r_data  = data;
    slave_r_resp  = resp;
    slave_r_last  = last;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (slave_r_ready) begin ok = 1'b1; break; end
    end
    check("slave_r_accept", ok, 1'b1);
    @(posedge clk); #1;
    slave_r_valid = 1'b0;
    slave_r_last  = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 100; i++) begin
      if (exp_r.size() == 0 && exp_ar.size() == 0) break;
      @(negedge clk);
    end
    check("queues_drained", 64'(exp_r.size() + exp_ar.size()), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic ok;

    // Reset state
    #12;
    check("rst_master_ar_ready", master_ar_ready, 1'b1);
    check("rst_master_r_valid", master_r_valid, 1'b0);
    check("rst_slave_ar_valid", slave_ar_valid, 1'b0);
    check("rst_slave_r_ready", slave_r_ready, 1'b0);
    @(posedge clk); #1;
    rstn = 1'b1;

    // Aligned 64-bit beat split into two 32-bit beats
    send_ar(2'd1, 32'h1000, 8'd0, 3'd3, 8'd1, 3'd2);
    push_r(64'h22222222_11111111, 2'd0, 1'b1, 2'd1);
    send_beat(2'd1, 32'h11111111, 2'd0, 1'b0);
    send_beat(2'd1, 32'h22222222, 2'd0, 1'b1);
    drain();

    // Unaligned start: first wide beat only holds its upper lane
    send_ar(2'd2, 32'h1004, 8'd1, 3'd3, 8'd2, 3'd2);
    push_r(64'hAAAA0001_00000000, 2'd0, 1'b0, 2'd2);
    push_r(64'hCCCC0003_BBBB0002, 2'd0, 1'b1, 2'd2);
    send_beat(2'd2, 32'hAAAA0001, 2'd0, 1'b0);
    send_beat(2'd2, 32'hBBBB0002, 2'd0, 1'b0);
    send_beat(2'd2, 32'hCCCC0003, 2'd0, 1'b1);
    drain();

    // Narrow master burst: each slave beat is its own master beat
    send_ar(2'd3, 32'h1004, 8'd1, 3'd2, 8'd1, 3'd2);
    push_r(64'hDDDD0004_00000000, 2'd0, 1'b0, 2'd3);
    push_r(64'h00000000_EEEE0005, 2'd0, 1'b1, 2'd3);
    send_beat(2'd3, 32'hDDDD0004, 2'd0, 1'b0);
    send_beat(2'd3, 32'hEEEE0005, 2'd0, 1'b1);
    drain();

    // Response accumulation: highest response of the group wins
    send_ar(2'd0, 32'h1000, 8'd0, 3'd3, 8'd1, 3'd2);
    push_r(64'h0000BEEF_0000DEAD, 2'd2, 1'b1, 2'd0);
    send_beat(2'd0, 32'h0000DEAD, 2'd2, 1'b0);
    send_beat(2'd0, 32'h0000BEEF, 2'd0, 1'b1);
    drain();

    // Backpressure on master R: data stable, slave stalled
    master_r_ready = 1'b0;
    send_ar(2'd1, 32'h2000, 8'd0, 3'd3, 8'd1, 3'd2);
    push_r(64'h5555AAAA_12345678, 2'd0, 1'b1, 2'd1);
    send_beat(2'd1, 32'h12345678, 2'd0, 1'b0);
    send_beat(2'd1, 32'h5555AAAA, 2'd0, 1'b1);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (master_r_valid) begin ok = 1'b1; break; end
    end
    check("hold_valid_seen", ok, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_valid", master_r_valid, 1'b1);
      check("hold_data", master_r_data, 64'h5555AAAA_12345678);
      check("hold_slave_r_ready", slave_r_ready, 1'b0);
    end
    @(posedge clk); #1;
    master_r_ready = 1'b1;
    drain();

    // Four-beat wide burst; response accumulator must clear between groups
    send_ar(2'd2, 32'h4000, 8'd3, 3'd3, 8'd7, 3'd2);
    for (int k = 0; k < 4; k++)
      push_r({32'h10000000 + 32'(2*k+1), 32'h10000000 + 32'(2*k)},
             (k == 2) ? 2'd1 : 2'd0, (k == 3), 2'd2);
    for (int i = 0; i < 8; i++)
      send_beat(2'd2, 32'h10000000 + 32'(i), (i == 5) ? 2'd1 : 2'd0, (i == 7));
    drain();

    // Halfword master burst starting at an odd halfword
    send_ar(2'd3, 32'h3002, 8'd1, 3'd1, 8'd1, 3'd1);
    push_r(64'h00000000_0000F00F, 2'd0, 1'b0, 2'd3);
    push_r(64'h0000B00B_00000000, 2'd0, 1'b1, 2'd3);
    send_beat(2'd3, 32'h0000F00F, 2'd0, 1'b0);
    send_beat(2'd3, 32'h0000B00B, 2'd0, 1'b1);
    drain();

    // Reset in the middle of a burst: partial beat must be dropped
    send_ar(2'd1, 32'h5000, 8'd0, 3'd3, 8'd1, 3'd2);
    send_beat(2'd1, 32'h0BADF00D, 2'd0, 1'b0);
    rstn = 1'b0;
    @(negedge clk);
    check("midrst_master_ar_ready", master_ar_ready, 1'b1);
    @(posedge clk); #1;
    rstn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("postrst_master_ar_ready", master_ar_ready, 1'b1);
      check("postrst_master_r_valid", master_r_valid, 1'b0);
      check("postrst_slave_ar_valid", slave_ar_valid, 1'b0);
      check("postrst_slave_r_ready", slave_r_ready, 1'b0);
    end
    check("postrst_buffer", master_r_data, 64'h0);

    // Recovery after reset
    send_ar(2'd0, 32'h6000, 8'd0, 3'd3, 8'd1, 3'd2);
    push_r(64'h66666666_77777777, 2'd0, 1'b1, 2'd0);
    send_beat(2'd0, 32'h77777777, 2'd0, 1'b0);
    send_beat(2'd0, 32'h66666666, 2'd0, 1'b1);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
